// File: rtl/mdu_hilo_if.sv
// ---------------------------------------------------------------------------
// mdu_hilo_if
// Issue/read bundle between the EX-stage controller and the multiply/divide
// unit.
//   master (controller): drives start, op, a, b, rd_hi; sees busy, hi, lo, rdata
//   slave  (mdu_hilo)  : the mirror image
// Signals:
//   start  issue strobe
//   op     3-bit operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO, others no-op)
//   a, b   rs / rt operands
//   rd_hi  read select for rdata (1 = HI, 0 = LO)
//   busy   multi-cycle operation in flight
//   hi, lo architectural HI/LO registers
//   rdata  rd_hi ? hi : lo, combinational
// ---------------------------------------------------------------------------
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    modport master (
        output start, op, a, b, rd_hi,
        input  busy, hi, lo, rdata
    );

    modport slave (
        input  start, op, a, b, rd_hi,
        output busy, hi, lo, rdata
    );
endinterface

// File: rtl/mdu_hilo.sv
// ---------------------------------------------------------------------------
// mdu_hilo
// Multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
// A MULT/MULTU/DIV/DIVU issue latches its operands and holds busy for
// MULT_CYCLES / DIV_CYCLES cycles; the result lands in HI/LO on the edge busy
// falls. MTHI/MTLO write in a single cycle without raising busy.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears busy, HI, LO, aborts op)
//   bus    mdu_hilo_if.slave: start/op/a/b/rd_hi in, busy/hi/lo/rdata out
// The arithmetic is a behavioural result block fed from the latched
// operands; the counter alone sets the visible latency.
// ---------------------------------------------------------------------------
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_hilo_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;

    // ---------------- result datapath (from latched operands) --------------
    logic [63:0] prod_s, prod_u;
    logic        is_div;
    logic [31:0] mag_a, mag_b;
    logic [31:0] div_n, div_d;
    logic [31:0] uq, ur;
    logic [31:0] res_q, res_r;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // One unsigned divider serves both DIV and DIVU: signed division runs on
    // magnitudes and the signs are restored afterwards. This also makes
    // 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case.
    assign is_div = (op_q == OP_DIV);
    assign mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    assign mag_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    assign div_n  = is_div ? mag_a : a_q;
    // Divisor forced nonzero so the operator stays defined; a zero divisor
    // never writes HI/LO anyway.
    assign div_d  = (b_q == 32'd0) ? 32'd1 : (is_div ? mag_b : b_q);
    assign uq     = div_n / div_d;
    assign ur     = div_n % div_d;
    assign res_q  = (is_div && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    assign res_r  = (is_div && a_q[31]) ? (32'd0 - ur) : ur;

    // ---------------- state register ----------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ---------------- next state / register updates -----------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CW'(MULT_CYCLES - 1);
                            op_d    = bus.op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CW'(DIV_CYCLES - 1);
                            op_d    = bus.op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;  // 000 / 111: no-op
                    endcase
                end
            end
            RUN: begin
                // start is deliberately not looked at here: anything issued
                // while busy is dropped.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = res_r;
                                lo_d = res_q;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------------------------------------
    assign bus.busy  = (state_q == RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    // Old HI/LO stay visible during RUN; the pending result is not bypassed.
    assign bus.rdata = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo
// Self-checking bench for mdu_hilo. A behavioural model (remaining-busy count
// plus plain integer arithmetic) tracks busy/HI/LO; a compare process checks
// every cycle, and directed scenarios pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic clk;
    logic rst_n;
    mdu_hilo_if bus();

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------------------------
    int          left;      // cycles of busy still to come
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint p;
        int     sa, sb, sq, sr;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {hi, lo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_op = OP_NONE;
            m_a  = 32'd0;
            m_b  = 32'd0;
        end else if (left > 0) begin
            left = left - 1;
            if (left == 0) {m_hi, m_lo} = ref_result(m_op, m_a, m_b, m_hi, m_lo);
        end else if (bus.start) begin
            case (bus.op)
                OP_MULT, OP_MULTU: begin
                    left = MC; m_op = bus.op; m_a = bus.a; m_b = bus.b;
                end
                OP_DIV, OP_DIVU: begin
                    left = DC; m_op = bus.op; m_a = bus.a; m_b = bus.b;
                end
                OP_MTHI: m_hi = bus.a;
                OP_MTLO: m_lo = bus.a;
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ---------------------------------
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("busy",  {31'd0, bus.busy}, {31'd0, left > 0});
            check("hi",    bus.hi, m_hi);
            check("lo",    bus.lo, m_lo);
            check("rdata", bus.rdata, bus.rd_hi ? m_hi : m_lo);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;   // operands must be latched, so scramble them
        bus.b     = $urandom;
    endtask

    // Counts negedges at which busy is seen high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.rd_hi = 1'b0;

        // 1. reset held
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_hi",    bus.hi, 32'd0);
        check("rst_lo",    bus.lo, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 2. MULT / MULTU
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult_cycles", n, MC);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);

        // 3. DIV / DIVU
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, DC);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", bus.lo, 32'h8000_0000);
        check("divovf_hi", bus.hi, 32'd0);

        // 4. divide by zero
        issue(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        issue(OP_DIV, 32'd5, 32'd0);
        wait_idle(n);
        check("div0_cycles", n, DC);
        check("div0_hi", bus.hi, 32'h1234);
        check("div0_lo", bus.lo, 32'h5678);

        // 5. MTHI and rdata select
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_lo", bus.lo, 32'h5678);
        bus.rd_hi = 1'b1;
        #1 check("rdata_hi", bus.rdata, 32'hDEAD_BEEF);
        bus.rd_hi = 1'b0;
        #1 check("rdata_lo", bus.rdata, 32'h5678);
        @(negedge clk);

        // 6. start while busy is ignored, then back-to-back issue
        issue(OP_MULT, 32'd3, 32'd4);
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'd9;
        @(negedge clk);
        bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);
        check("ign_cycles", n + 2, MC);
        check("ign_hi", bus.hi, 32'd0);
        check("ign_lo", bus.lo, 32'd12);
        issue(OP_MULTU, 32'd5, 32'd6);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle(n);
        check("b2b_lo", bus.lo, 32'd30);

        // 1b. asynchronous reset in the middle of a DIV
        issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // random traffic, including starts while busy
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 2) != 0);
            bus.op    = 3'($urandom);
            bus.a     = rnd32();
            bus.b     = rnd32();
            bus.rd_hi = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (DC + 2) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
